time_entry: RTL and testbench

TIME_ENTRY -- requirements
Module: time_entry

---
 rtl/time_entry.sv | 213 +++++++++++++++++++++
 tb/tb_time_entry.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/time_entry.sv
// time_entry: keypad time-setting front end.
// Collects up to four BCD digits {H10,H1,M10,M1}, supports backspace,
// cancel and enter, validates the entry as a 24-hour time and hands the
// result to the counting logic as new_time plus a one-cycle set_time pulse.
// Optional build macro: TIME_ENTRY_TIMEOUT_EN abandons an unfinished entry
// (or an unacknowledged error) after TIMEOUT_CYCLES idle clock cycles.
//
// Key handshake: a key is taken on a rising clk edge when key_valid and
// key_ready are both high; a key offered while key_ready is low is dropped,
// never queued, and the source need not hold it.
//
// Commit timing: new_time is loaded on the CHECK->COMMIT edge and set_time is
// registered from the COMMIT state, so new_time has been stable for one full
// cycle when set_time rises and stays unchanged afterwards.
module time_entry #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        key_ready,
    output logic [15:0] new_time,
    output logic        set_time,
    output logic [15:0] entry_digits,
    output logic [2:0]  digit_count,
    output logic        entry_active,
    output logic        entry_error,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENTRY  = 3'd1,
        ST_CHECK  = 3'd2,
        ST_COMMIT = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_BACK   = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    state_t      state_q, state_d;
    logic [15:0] digits_q, digits_d;
    logic [2:0]  count_q, count_d;
    logic [15:0] new_time_q, new_time_d;
    logic        set_time_q;

    logic        key_acc;
    logic        is_digit;
    logic        entry_ok;

    assign key_ready = (state_q == ST_IDLE) || (state_q == ST_ENTRY) ||
                       (state_q == ST_ERROR);
    assign key_acc   = key_valid && key_ready;
    assign is_digit  = (key_code <= 4'd9);

    // 24-hour validity of the four-digit buffer {H10,H1,M10,M1}.
    assign entry_ok = (count_q == 3'd4) &&
                      (digits_q[15:12] <= 4'd2) &&
                      (digits_q[11:8]  <= 4'd9) &&
                      (digits_q[7:4]   <= 4'd5) &&
                      (digits_q[3:0]   <= 4'd9) &&
                      ((digits_q[15:12] < 4'd2) || (digits_q[11:8] <= 4'd3));

`ifdef TIME_ENTRY_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_run;
    logic             tmo_hit;

    // The counter only runs while waiting on the user in ENTRY or ERROR.
    assign tmo_run = ((state_q == ST_ENTRY) || (state_q == ST_ERROR)) && !key_acc;
    assign tmo_hit = tmo_run && (tmo_q == TMO_LAST);

    // Idle-cycle counter: cleared by any accepted key or outside ENTRY/ERROR.
    always_comb begin
        tmo_d = '0;
        if (tmo_run && !tmo_hit) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    // Next-state, buffer and committed-time logic.
    always_comb begin
        state_d    = state_q;
        digits_d   = digits_q;
        count_d    = count_q;
        new_time_d = new_time_q;

        unique case (state_q)
            ST_IDLE: begin
                if (key_acc && is_digit) begin
                    digits_d = {key_code, 12'h000};
                    count_d  = 3'd1;
                    state_d  = ST_ENTRY;
                end
            end

            ST_ENTRY: begin
                if (key_acc) begin
                    if (is_digit) begin
                        // A fifth digit is ignored; the buffer stays full.
                        if (count_q < 3'd4) begin
                            case (count_q)
                                3'd1:    digits_d[11:8] = key_code;
                                3'd2:    digits_d[7:4]  = key_code;
                                3'd3:    digits_d[3:0]  = key_code;
                                default: digits_d       = digits_q;
                            endcase
                            count_d = count_q + 3'd1;
                        end
                    end else if (key_code == KEY_ENTER) begin
                        state_d = ST_CHECK;
                    end else if (key_code == KEY_BACK) begin
                        case (count_q)
                            3'd1:    digits_d[15:12] = 4'h0;
                            3'd2:    digits_d[11:8]  = 4'h0;
                            3'd3:    digits_d[7:4]   = 4'h0;
                            3'd4:    digits_d[3:0]   = 4'h0;
                            default: digits_d        = digits_q;
                        endcase
                        count_d = count_q - 3'd1;
                        if (count_q == 3'd1) begin
                            state_d = ST_IDLE;
                        end
                    end else if (key_code == KEY_CANCEL) begin
                        digits_d = '0;
                        count_d  = '0;
                        state_d  = ST_IDLE;
                    end
                end
            end

            ST_CHECK: begin
                if (entry_ok) begin
                    new_time_d = digits_q;
                    state_d    = ST_COMMIT;
                end else begin
                    state_d = ST_ERROR;
                end
            end

            ST_COMMIT: begin
                digits_d = '0;
                count_d  = '0;
                state_d  = ST_IDLE;
            end

            ST_ERROR: begin
                // Whatever key acknowledges the error is discarded.
                if (key_acc) begin
                    digits_d = '0;
                    count_d  = '0;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                digits_d = '0;
                count_d  = '0;
                state_d  = ST_IDLE;
            end
        endcase

`ifdef TIME_ENTRY_TIMEOUT_EN
        if (tmo_hit) begin
            digits_d = '0;
            count_d  = '0;
            state_d  = ST_IDLE;
        end
`endif
    end

    // State, buffer, committed time and set_time registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            digits_q   <= '0;
            count_q    <= '0;
            new_time_q <= '0;
            set_time_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            digits_q   <= digits_d;
            count_q    <= count_d;
            new_time_q <= new_time_d;
            set_time_q <= (state_q == ST_COMMIT);
        end
    end

    assign new_time     = new_time_q;
    assign set_time     = set_time_q;
    assign entry_digits = digits_q;
    assign digit_count  = count_q;
    assign entry_active = (state_q != ST_IDLE);
    assign entry_error  = (state_q == ST_ERROR);
    assign fsm_state    = state_q;

endmodule

// File: tb/tb_time_entry.sv
// Directed bench for time_entry: key sequences with hand-computed results.
module tb_time_entry;

`ifdef TIME_ENTRY_TIMEOUT_EN
    localparam int unsigned TMO = 16;
`else
    localparam int unsigned TMO = 1000;
`endif

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ENTRY  = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_COMMIT = 3'd3;
    localparam logic [2:0] S_ERROR  = 3'd4;

    logic        clk;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    logic [15:0] new_time;
    logic        set_time;
    logic [15:0] entry_digits;
    logic [2:0]  digit_count;
    logic        entry_active;
    logic        entry_error;
    logic [2:0]  fsm_state;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    logic [15:0] exp_q[$];

    time_entry #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_ready    (key_ready),
        .new_time     (new_time),
        .set_time     (set_time),
        .entry_digits (entry_digits),
        .digit_count  (digit_count),
        .entry_active (entry_active),
        .entry_error  (entry_error),
        .fsm_state    (fsm_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Press one key: drive at negedge, sampled at the following posedge,
    // return at the next negedge (just after the accepting edge).
    task automatic press(input logic [3:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: every set_time pulse must match the next expected commit
    // and must last exactly one sampled cycle.
    logic prev_set = 1'b0;
    always @(negedge clk) begin
        if (reset && set_time) begin
            pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected_set_time", 16'(set_time), 16'h0);
            end else begin
                check("commit_value", new_time, exp_q.pop_front());
            end
            check("set_time_width", 16'(prev_set), 16'h0);
        end
        prev_set = set_time;
    end

    initial begin
        int p0;
        reset     = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        #12;
        check("rst_state", 16'(fsm_state), 16'(S_IDLE));
        check("rst_new_time", new_time, 16'h0000);
        check("rst_set_time", 16'(set_time), 16'h0);
        check("rst_key_ready", 16'(key_ready), 16'h1);
        check("rst_active", 16'(entry_active), 16'h0);
        @(negedge clk);
        reset = 1'b1;
        idle(2);

        // Non-digit keys in IDLE are ignored.
        press(4'hA); press(4'hB); press(4'hE);
        check("idle_ignore_state", 16'(fsm_state), 16'(S_IDLE));
        check("idle_ignore_count", 16'(digit_count), 16'h0);

        // 1,2,3,4,ENTER -> 12:34 with keys offered in CHECK/COMMIT dropped.
        press(4'h1);
        check("echo1_digits", entry_digits, 16'h1000);
        check("echo1_active", 16'(entry_active), 16'h1);
        press(4'h2);
        check("echo2_digits", entry_digits, 16'h1200);
        check("echo2_count", 16'(digit_count), 16'h2);
        press(4'h3); press(4'h4);
        check("echo4_digits", entry_digits, 16'h1234);
        exp_q.push_back(16'h1234);
        p0 = pulses;
        press(4'hA);
        check("t1_check_state", 16'(fsm_state), 16'(S_CHECK));
        check("t1_check_ready", 16'(key_ready), 16'h0);
        check("t1_check_newtime", new_time, 16'h0000);
        key_valid = 1'b1; key_code = 4'h5;
        @(negedge clk);
        check("t1_commit_state", 16'(fsm_state), 16'(S_COMMIT));
        check("t1_commit_newtime", new_time, 16'h1234);
        check("t1_commit_set_low", 16'(set_time), 16'h0);
        @(negedge clk);
        key_valid = 1'b0; key_code = 4'h0;
        check("t1_pulse", 16'(set_time), 16'h1);
        check("t1_idle_state", 16'(fsm_state), 16'(S_IDLE));
        check("t1_idle_digits", entry_digits, 16'h0000);
        check("t1_dropped_count", 16'(digit_count), 16'h0);
        idle(2);
        check("t1_pulse_count", 16'(pulses - p0), 16'h1);

        // 2,4,0,0,ENTER -> ERROR; next key 5 discarded.
        p0 = pulses;
        press(4'h2); press(4'h4); press(4'h0); press(4'h0); press(4'hA);
        idle(1);
        check("t2_error_state", 16'(fsm_state), 16'(S_ERROR));
        check("t2_error_flag", 16'(entry_error), 16'h1);
        check("t2_newtime_kept", new_time, 16'h1234);
        check("t2_ready", 16'(key_ready), 16'h1);
        idle(3);
        press(4'h5);
        check("t2_recover_state", 16'(fsm_state), 16'(S_IDLE));
        check("t2_recover_flag", 16'(entry_error), 16'h0);
        check("t2_recover_count", 16'(digit_count), 16'h0);
        check("t2_recover_digits", entry_digits, 16'h0000);
        check("t2_no_pulse", 16'(pulses - p0), 16'h0);

        // 1,7,5,9,(6 ignored),BACK,8,ENTER -> 17:58.
        p0 = pulses;
        press(4'h1); press(4'h7); press(4'h5); press(4'h9); press(4'h6);
        check("t3_fifth_digits", entry_digits, 16'h1759);
        check("t3_fifth_count", 16'(digit_count), 16'h4);
        press(4'hB);
        check("t3_back_digits", entry_digits, 16'h1750);
        check("t3_back_count", 16'(digit_count), 16'h3);
        press(4'h8);
        exp_q.push_back(16'h1758);
        press(4'hA);
        idle(4);
        check("t3_newtime", new_time, 16'h1758);
        check("t3_pulse_count", 16'(pulses - p0), 16'h1);

        // 1,2,ENTER -> ERROR with two digits; recover, then 23:59.
        press(4'h1); press(4'h2); press(4'hA);
        idle(1);
        check("t4_short_error", 16'(fsm_state), 16'(S_ERROR));
        check("t4_short_count", 16'(digit_count), 16'h2);
        press(4'hC);
        check("t4_recover", 16'(fsm_state), 16'(S_IDLE));
        p0 = pulses;
        press(4'h2); press(4'h3); press(4'h5); press(4'h9);
        exp_q.push_back(16'h2359);
        press(4'hA);
        idle(4);
        check("t4_newtime", new_time, 16'h2359);
        check("t4_pulse_count", 16'(pulses - p0), 16'h1);

        // Minutes tens of 6 is rejected.
        press(4'h1); press(4'h9); press(4'h6); press(4'h0); press(4'hA);
        idle(1);
        check("t5_m10_error", 16'(entry_error), 16'h1);
        check("t5_newtime_kept", new_time, 16'h2359);
        press(4'h0);

        // 00:00 is valid; reserved key mid-entry ignored.
        p0 = pulses;
        press(4'h0); press(4'h0); press(4'hF); press(4'h0); press(4'h0);
        check("t6_reserved_count", 16'(digit_count), 16'h4);
        exp_q.push_back(16'h0000);
        press(4'hA);
        idle(4);
        check("t6_newtime", new_time, 16'h0000);
        check("t6_pulse_count", 16'(pulses - p0), 16'h1);

        // Backspace to empty returns to IDLE; cancel clears the buffer.
        press(4'h3); press(4'hB);
        check("t7_back_idle", 16'(fsm_state), 16'(S_IDLE));
        press(4'h1); press(4'h4); press(4'hC);
        check("t7_cancel_state", 16'(fsm_state), 16'(S_IDLE));
        check("t7_cancel_digits", entry_digits, 16'h0000);

        // Timeout behaviour.
        press(4'h1);
`ifdef TIME_ENTRY_TIMEOUT_EN
        idle(15);
        check("t8_before_timeout", 16'(fsm_state), 16'(S_ENTRY));
        idle(1);
        check("t8_timeout_state", 16'(fsm_state), 16'(S_IDLE));
        check("t8_timeout_count", 16'(digit_count), 16'h0);
`else
        idle(1000);
        check("t8_no_timeout_state", 16'(fsm_state), 16'(S_ENTRY));
        check("t8_no_timeout_count", 16'(digit_count), 16'h1);
        press(4'hC);
`endif

        // Reset during COMMIT: asynchronous clear, no pending pulse.
        p0 = pulses;
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hA);
        @(negedge clk);
        check("t9_in_commit", 16'(fsm_state), 16'(S_COMMIT));
        #2 reset = 1'b0;
        #1;
        check("t9_async_set", 16'(set_time), 16'h0);
        check("t9_async_newtime", new_time, 16'h0000);
        check("t9_async_state", 16'(fsm_state), 16'(S_IDLE));
        @(negedge clk);
        reset = 1'b1;
        idle(3);
        check("t9_ready", 16'(key_ready), 16'h1);
        check("t9_state", 16'(fsm_state), 16'(S_IDLE));
        check("t9_no_pulse", 16'(pulses - p0), 16'h0);
        check("t9_queue_empty", 16'(exp_q.size()), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
